object_line_scheduler: RTL and testbench

OBJECT_LINE_SCHEDULER -- requirements
Module: object_line_scheduler

---
 rtl/object_line_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_object_line_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/object_line_scheduler.sv
// Per-line sprite scheduler: picks up to two visible objects covering the next raster line
// from a frame-latched object table, with a shadow table for glitch-free CPU updates.
module object_line_scheduler (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       wr_en,
   input  logic [1:0] wr_idx,
   input  logic [9:0] wr_x,
   input  logic [9:0] wr_y,
   input  logic [9:0] wr_size,
   input  logic       wr_vis,
   output logic       slot0_valid,
   output logic       slot1_valid,
   output logic [1:0] slot0_id,
   output logic [1:0] slot1_id,
   output logic [9:0] slot0_x,
   output logic [9:0] slot0_y,
   output logic [9:0] slot0_size,
   output logic [9:0] slot1_x,
   output logic [9:0] slot1_y,
   output logic [9:0] slot1_size,
   output logic       line_overflow,
   output logic       busy
);

   typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

   state_e     state_q, state_d;
   logic [1:0] scan_idx_q;
   logic [9:0] line_q;

   logic [9:0] sh_x [4];
   logic [9:0] sh_y [4];
   logic [9:0] sh_size [4];
   logic       sh_vis [4];
   logic [9:0] act_x [4];
   logic [9:0] act_y [4];
   logic [9:0] act_size [4];
   logic       act_vis [4];

   logic       p0_valid, p1_valid, p_ovf;
   logic [1:0] p0_id, p1_id;
   logic [9:0] p0_x, p0_y, p0_size, p1_x, p1_y, p1_size;

   logic        frame_commit, line_trigger;
   logic [9:0]  next_line;
   logic [9:0]  cur_x, cur_y, cur_size;
   logic        cur_vis;
   logic [9:0]  lo;
   logic [10:0] hi;
   logic        hit;

   assign frame_commit = (DrawY == 10'd480) && (DrawX == 10'd0);
   assign line_trigger = (DrawX == 10'd640);
   assign next_line    = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;

   assign cur_x    = act_x[scan_idx_q];
   assign cur_y    = act_y[scan_idx_q];
   assign cur_size = act_size[scan_idx_q];
   assign cur_vis  = act_vis[scan_idx_q];

   // Top of the object clamps at line 0; bottom gets an extra bit so it cannot wrap.
   assign lo  = (cur_size > cur_y) ? 10'd0 : cur_y - cur_size;
   assign hi  = {1'b0, cur_y} + {1'b0, cur_size};
   assign hit = cur_vis && (line_q >= lo) && ({1'b0, line_q} <= hi);

   assign busy = (state_q != StIdle);

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            sh_x[i]     <= '0;
            sh_y[i]     <= '0;
            sh_size[i]  <= '0;
            sh_vis[i]   <= 1'b0;
            act_x[i]    <= '0;
            act_y[i]    <= '0;
            act_size[i] <= '0;
            act_vis[i]  <= 1'b0;
         end
      end else begin
         // Non-blocking copy means a coincident write lands in shadow only.
         if (frame_commit) begin
            for (int i = 0; i < 4; i++) begin
               act_x[i]    <= sh_x[i];
               act_y[i]    <= sh_y[i];
               act_size[i] <= sh_size[i];
               act_vis[i]  <= sh_vis[i];
            end
         end
         if (wr_en) begin
            sh_x[wr_idx]    <= wr_x;
            sh_y[wr_idx]    <= wr_y;
            sh_size[wr_idx] <= wr_size;
            sh_vis[wr_idx]  <= wr_vis;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (line_trigger && (next_line < 10'd480)) state_d = StScan;
         StScan:   if (scan_idx_q == 2'd3) state_d = StCommit;
         StCommit: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         scan_idx_q    <= '0;
         line_q        <= '0;
         p0_valid      <= 1'b0;
         p0_id         <= '0;
         p0_x          <= '0;
         p0_y          <= '0;
         p0_size       <= '0;
         p1_valid      <= 1'b0;
         p1_id         <= '0;
         p1_x          <= '0;
         p1_y          <= '0;
         p1_size       <= '0;
         p_ovf         <= 1'b0;
         slot0_valid   <= 1'b0;
         slot0_id      <= '0;
         slot0_x       <= '0;
         slot0_y       <= '0;
         slot0_size    <= '0;
         slot1_valid   <= 1'b0;
         slot1_id      <= '0;
         slot1_x       <= '0;
         slot1_y       <= '0;
         slot1_size    <= '0;
         line_overflow <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            StIdle: begin
               if (state_d == StScan) begin
                  line_q     <= next_line;
                  scan_idx_q <= '0;
                  p0_valid   <= 1'b0;
                  p0_id      <= '0;
                  p0_x       <= '0;
                  p0_y       <= '0;
                  p0_size    <= '0;
                  p1_valid   <= 1'b0;
                  p1_id      <= '0;
                  p1_x       <= '0;
                  p1_y       <= '0;
                  p1_size    <= '0;
                  p_ovf      <= 1'b0;
               end
            end
            StScan: begin
               scan_idx_q <= scan_idx_q + 2'd1;
               if (hit) begin
                  if (!p0_valid) begin
                     p0_valid <= 1'b1;
                     p0_id    <= scan_idx_q;
                     p0_x     <= cur_x;
                     p0_y     <= cur_y;
                     p0_size  <= cur_size;
                  end else if (!p1_valid) begin
                     p1_valid <= 1'b1;
                     p1_id    <= scan_idx_q;
                     p1_x     <= cur_x;
                     p1_y     <= cur_y;
                     p1_size  <= cur_size;
                  end else begin
                     p_ovf <= 1'b1;
                  end
               end
            end
            StCommit: begin
               slot0_valid   <= p0_valid;
               slot0_id      <= p0_id;
               slot0_x       <= p0_x;
               slot0_y       <= p0_y;
               slot0_size    <= p0_size;
               slot1_valid   <= p1_valid;
               slot1_id      <= p1_id;
               slot1_x       <= p1_x;
               slot1_y       <= p1_y;
               slot1_size    <= p1_size;
               line_overflow <= p_ovf;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_object_line_scheduler.sv
// Self-checking bench: raster position is driven directly around DrawX=640 per line,
// with a reference object table model feeding an expected-result queue.
module tb_object_line_scheduler;

   logic       vga_clk = 1'b0;
   logic       reset_n;
   logic [9:0] DrawX, DrawY;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic [9:0] wr_x, wr_y, wr_size;
   logic       wr_vis;
   logic       slot0_valid, slot1_valid, line_overflow, busy;
   logic [1:0] slot0_id, slot1_id;
   logic [9:0] slot0_x, slot0_y, slot0_size, slot1_x, slot1_y, slot1_size;

   object_line_scheduler dut (
      .vga_clk       (vga_clk),
      .reset_n       (reset_n),
      .DrawX         (DrawX),
      .DrawY         (DrawY),
      .wr_en         (wr_en),
      .wr_idx        (wr_idx),
      .wr_x          (wr_x),
      .wr_y          (wr_y),
      .wr_size       (wr_size),
      .wr_vis        (wr_vis),
      .slot0_valid   (slot0_valid),
      .slot1_valid   (slot1_valid),
      .slot0_id      (slot0_id),
      .slot1_id      (slot1_id),
      .slot0_x       (slot0_x),
      .slot0_y       (slot0_y),
      .slot0_size    (slot0_size),
      .slot1_x       (slot1_x),
      .slot1_y       (slot1_y),
      .slot1_size    (slot1_size),
      .line_overflow (line_overflow),
      .busy          (busy)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct packed {
      logic       v0;
      logic [1:0] id0;
      logic [9:0] x0, y0, s0;
      logic       v1;
      logic [1:0] id1;
      logic [9:0] x1, y1, s1;
      logic       ovf;
   } exp_t;

   int checks = 0;
   int failures = 0;
   exp_t sb_q[$];
   exp_t last_exp = '0;

   int sh_x[4], sh_y[4], sh_s[4], sh_v[4];
   int act_x[4], act_y[4], act_s[4], act_v[4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) begin
         sh_x[i] = 0; sh_y[i] = 0; sh_s[i] = 0; sh_v[i] = 0;
         act_x[i] = 0; act_y[i] = 0; act_s[i] = 0; act_v[i] = 0;
      end
      last_exp = '0;
   endtask

   // Signed span test; a negative top edge is equivalent to clamping at zero.
   function automatic exp_t model_line(input int l);
      exp_t e;
      int   n;
      e = '0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (act_v[i] != 0 && l >= act_y[i] - act_s[i] && l <= act_y[i] + act_s[i]) begin
            if (n == 0) begin
               e.v0 = 1'b1; e.id0 = 2'(i);
               e.x0 = 10'(act_x[i]); e.y0 = 10'(act_y[i]); e.s0 = 10'(act_s[i]);
            end else if (n == 1) begin
               e.v1 = 1'b1; e.id1 = 2'(i);
               e.x1 = 10'(act_x[i]); e.y1 = 10'(act_y[i]); e.s1 = 10'(act_s[i]);
            end else begin
               e.ovf = 1'b1;
            end
            n++;
         end
      end
      return e;
   endfunction

   task automatic drive_write(input int idx, input int x, input int y, input int s, input int v);
      wr_en = 1'b1; wr_idx = 2'(idx);
      wr_x = 10'(x); wr_y = 10'(y); wr_size = 10'(s); wr_vis = v[0];
   endtask

   task automatic write_obj(input int idx, input int x, input int y, input int s, input int v);
      drive_write(idx, x, y, s, v);
      step();
      wr_en = 1'b0;
      sh_x[idx] = x; sh_y[idx] = y; sh_s[idx] = s; sh_v[idx] = v;
   endtask

   task automatic commit_frame(input bit w, input int idx, input int x, input int y,
                               input int s, input int v);
      DrawY = 10'd480;
      DrawX = 10'd0;
      if (w) drive_write(idx, x, y, s, v);
      step();
      wr_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         act_x[i] = sh_x[i]; act_y[i] = sh_y[i]; act_s[i] = sh_s[i]; act_v[i] = sh_v[i];
      end
      if (w) begin
         sh_x[idx] = x; sh_y[idx] = y; sh_s[idx] = s; sh_v[idx] = v;
      end
      DrawX = 10'd700;
      DrawY = 10'd0;
   endtask

   task automatic run_line(input int y);
      int   l;
      exp_t e;
      l = (y == 524) ? 0 : y + 1;
      e = (l < 480) ? model_line(l) : last_exp;
      sb_q.push_back(e);
      last_exp = e;
      DrawY = 10'(y);
      for (int x = 636; x <= 650; x++) begin
         DrawX = 10'(x);
         if (x == 641) check($sformatf("busy_scan_y%0d", y), 32'(busy), 32'(l < 480));
         if (x == 646) begin
            e = sb_q.pop_front();
            check($sformatf("slot0_valid_y%0d", y), 32'(slot0_valid), 32'(e.v0));
            check($sformatf("slot0_id_y%0d", y), 32'(slot0_id), 32'(e.id0));
            check($sformatf("slot0_x_y%0d", y), 32'(slot0_x), 32'(e.x0));
            check($sformatf("slot0_y_y%0d", y), 32'(slot0_y), 32'(e.y0));
            check($sformatf("slot0_size_y%0d", y), 32'(slot0_size), 32'(e.s0));
            check($sformatf("slot1_valid_y%0d", y), 32'(slot1_valid), 32'(e.v1));
            check($sformatf("slot1_id_y%0d", y), 32'(slot1_id), 32'(e.id1));
            check($sformatf("slot1_x_y%0d", y), 32'(slot1_x), 32'(e.x1));
            check($sformatf("slot1_y_y%0d", y), 32'(slot1_y), 32'(e.y1));
            check($sformatf("slot1_size_y%0d", y), 32'(slot1_size), 32'(e.s1));
            check($sformatf("overflow_y%0d", y), 32'(line_overflow), 32'(e.ovf));
            check($sformatf("busy_done_y%0d", y), 32'(busy), 32'd0);
         end
         step();
      end
      DrawX = 10'd700;
   endtask

   initial begin
      reset_n = 1'b0;
      DrawX = 10'd700; DrawY = 10'd0;
      wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_size = '0; wr_vis = 1'b0;
      clear_model();
      step();
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_slot0_valid", 32'(slot0_valid), 32'd0);
      check("rst_slot1_valid", 32'(slot1_valid), 32'd0);
      check("rst_overflow", 32'(line_overflow), 32'd0);
      reset_n = 1'b1;
      step();

      // Single object and its span edges.
      write_obj(1, 100, 50, 8, 1);
      commit_frame(1'b0, 0, 0, 0, 0, 0);
      run_line(41);
      run_line(57);
      run_line(40);
      run_line(58);

      // Four objects on one line.
      for (int i = 0; i < 4; i++) write_obj(i, 10 * i + 5, 200, 5, 1);
      commit_frame(1'b0, 0, 0, 0, 0, 0);
      run_line(199);
      run_line(205);

      // Clamp at top and vertical-blank wrap.
      write_obj(0, 0, 0, 0, 0);
      write_obj(1, 0, 0, 0, 0);
      write_obj(3, 0, 0, 0, 0);
      write_obj(2, 7, 3, 10, 1);
      commit_frame(1'b0, 0, 0, 0, 0, 0);
      run_line(524);
      run_line(479);
      run_line(13);

      // Write racing the frame commit.
      write_obj(2, 0, 0, 0, 0);
      write_obj(0, 20, 50, 2, 1);
      commit_frame(1'b0, 0, 0, 0, 0, 0);
      commit_frame(1'b1, 0, 20, 300, 2, 1);
      run_line(49);
      commit_frame(1'b0, 0, 0, 0, 0, 0);
      run_line(49);
      run_line(299);

      // Reset in the middle of a scan.
      DrawY = 10'd299;
      for (int x = 636; x <= 650; x++) begin
         DrawX = 10'(x);
         if (x == 642) begin
            reset_n = 1'b0;
            #1;
            check("midrst_slot0_valid", 32'(slot0_valid), 32'd0);
            check("midrst_slot0_x", 32'(slot0_x), 32'd0);
            check("midrst_busy", 32'(busy), 32'd0);
         end
         if (x == 643) reset_n = 1'b1;
         if (x == 646) begin
            check("postrst_slot0_valid", 32'(slot0_valid), 32'd0);
            check("postrst_busy", 32'(busy), 32'd0);
         end
         step();
      end
      DrawX = 10'd700;
      clear_model();
      run_line(299);
      commit_frame(1'b0, 0, 0, 0, 0, 0);
      run_line(299);
      write_obj(3, 33, 100, 1, 1);
      commit_frame(1'b0, 0, 0, 0, 0, 0);
      run_line(99);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
